bcd_counter: RTL and testbench
==============================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameter DIGITS, default 1: number of cascaded BCD decades; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  count enable; high = advance one step per clock.
REQ-005 up_dn  input  1  direction; 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous parallel load request.
REQ-007 load_val  input  4*DIGITS  value to load; digit k occupies bits [4k+3:4k].
REQ-008 q  output  4*DIGITS  current count; digit 0 (least significant) is in q[3:0].
REQ-009 carry_out  output  1  terminal-count flag for cascading.

Function
REQ-010 Each digit SHALL only ever hold a value from 0 to 9.
REQ-011 With en=1 and up_dn=1, digit 0 SHALL increment by one each clock, and 9 SHALL wrap to 0.
REQ-012 With en=1 and up_dn=0, digit 0 SHALL decrement by one each clock, and 0 SHALL wrap to 9.
REQ-013 Digit k>0 SHALL step only in a cycle where every lower digit is at its terminal value: 9 when counting up, 0 when counting down. All digits SHALL update on the same edge, with no ripple delay.
REQ-014 With en=0 and load=0, q SHALL hold its value.
REQ-015 carry_out SHALL be combinational: 1 when en=1 and every digit is at its terminal value for the current up_dn, else 0.
REQ-016 Example: DIGITS=1, counting up with q=9 gives carry_out=1; on the next edge q becomes 0.
REQ-017 q SHALL change only on a rising clk edge or on reset assertion; latency from input to q is one clock.
REQ-018 Wrap-around SHALL be full: for DIGITS=2 counting up, 99 goes to 00; counting down, 00 goes to 99.

Reset
REQ-019 rst=0 SHALL immediately force q to all zeros, independent of clk.
REQ-020 Reset assertion mid-count SHALL override en and load.
REQ-021 After rst returns to 1, the first enabled edge SHALL move q from 0 to 1 when counting up.
REQ-022 carry_out during reset SHALL follow REQ-015 with q=0.

Configuration
REQ-023 Macro BCD_COUNTER_LOAD_EN SHALL control the load feature.
REQ-024 With BCD_COUNTER_LOAD_EN defined, load=1 on a clock edge SHALL write load_val into q, overriding en.
REQ-025 With BCD_COUNTER_LOAD_EN defined, any load_val digit above 9 SHALL be stored as 0 in that digit; the other digits SHALL load normally.
REQ-026 Without BCD_COUNTER_LOAD_EN, the load and load_val ports SHALL still exist but SHALL be ignored.

Structure
REQ-027 Shared package bcd_counter_pkg SHALL hold the constants BCD_MAX=4'd9, BCD_MIN=4'd0 and DIGIT_W=4, plus a typedef bcd_digit_t (4-bit logic).
REQ-028 Sub-module bcd_digit SHALL implement one decade with inputs clk, rst, step, up_dn, load and load_val, and outputs q and tc.
REQ-029 bcd_counter SHALL instantiate DIGITS copies of bcd_digit through a generate loop and chain their tc outputs into the step inputs.

Verification
REQ-030 Reset pulse, then en=1, up_dn=1 for 12 clocks with DIGITS=1: q = 1,2,...,9,0,1,2; carry_out=1 exactly while q=9.
REQ-031 en=1, up_dn=0 starting from 0: q = 9,8,7...; carry_out=1 while q=0.
REQ-032 Assert rst=0 between clock edges while q=6: q=0 immediately, before the next edge; count resumes at 1 after release.
REQ-033 With the macro defined, load=1 with load_val=4'h7, then 4'hC: q=7, then q=0; with load=1 and en=1 together, load wins.
REQ-034 DIGITS=2, up, starting from 09: next edge gives 10; from 99 the next edge gives 00, with carry_out=1 in the 99 cycle.
REQ-035 en=0 for 5 clocks at q=4: q stays 4 and carry_out stays 0.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and types for the cascaded BCD counter.
package bcd_counter_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade (0..9) with up/down stepping and an optional parallel load.
// tc is the step request for the next decade: this decade is stepping and
// sits at its terminal value (9 going up, 0 going down).
// Build option: define BCD_COUNTER_LOAD_EN to enable the load/load_val path;
// otherwise those inputs are accepted but have no effect.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       load,
    input  bcd_digit_t load_val,
    output bcd_digit_t q,
    output logic       tc
);

    bcd_digit_t nxt;
    logic       at_term;

`ifdef BCD_COUNTER_LOAD_EN
    // Codes 10..15 are not decimal digits; they load as zero.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t v);
        return (v > BCD_MAX) ? BCD_MIN : v;
    endfunction
`else
    logic unused_load;
    assign unused_load = ^{load, load_val};
`endif

    // Next value with decimal wrap in either direction, plus terminal detect.
    always_comb begin
        nxt     = q;
        at_term = 1'b0;
        if (up_dn) begin
            at_term = (q == BCD_MAX);
            nxt     = at_term ? BCD_MIN : q + 4'd1;
        end else begin
            at_term = (q == BCD_MIN);
            nxt     = at_term ? BCD_MAX : q - 4'd1;
        end
    end

    assign tc = step & at_term;

    // Digit register: async clear, then load (if built in), then step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BCD_MIN;
        end
`ifdef BCD_COUNTER_LOAD_EN
        else if (load) begin
            q <= bcd_sanitize(load_val);
        end
`endif
        else if (step) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Cascaded synchronous BCD up/down counter of DIGITS decades (1..8).
// All decades share one clock edge; the step enable for each decade is formed
// combinationally from the lower decades, so there is no ripple delay.
// carry_out is high when enabled and every decade is at its terminal value.
// Build option: define BCD_COUNTER_LOAD_EN to enable synchronous parallel load.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  carry_out
);

    // step[k] enables decade k; step[DIGITS] is the overall terminal count.
    logic [DIGITS:0] step;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter: DIGITS must be in 1..8");
    end

    assign step[0] = en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .step     (step[k]),
            .up_dn    (up_dn),
            .load     (load),
            .load_val (load_val[DIGIT_W*k +: DIGIT_W]),
            .q        (q[DIGIT_W*k +: DIGIT_W]),
            .tc       (step[k+1])
        );
    end

    assign carry_out = step[DIGITS];

endmodule

// File: tb/tb_bcd_counter.sv
// Directed testbench for bcd_counter: a 1-decade and a 2-decade instance
// driven by shared controls, checked against hand-computed values.
module tb_bcd_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] lv1;
    logic [7:0] lv2;
    logic [3:0] q1;
    logic [7:0] q2;
    logic       co1;
    logic       co2;

    int n_cmp = 0;
    int n_err = 0;

    bcd_counter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv1), .q(q1), .carry_out(co1)
    );

    bcd_counter #(.DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv2), .q(q2), .carry_out(co2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        en = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; lv1 = 4'd0; lv2 = 8'h00;
        #1;
        n_cmp++; if (q1 !== 4'd0) begin n_err++; $display("FAIL reset_q1: got %h required 0", q1); end
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL reset_q2: got %h required 00", q2); end
        n_cmp++; if (co1 !== 1'b0) begin n_err++; $display("FAIL reset_co_en0: got %b required 0", co1); end
        en = 1'b1; up_dn = 1'b0;
        #1;
        n_cmp++; if (co1 !== 1'b1) begin n_err++; $display("FAIL reset_co1_down: got %b required 1", co1); end
        n_cmp++; if (co2 !== 1'b1) begin n_err++; $display("FAIL reset_co2_down: got %b required 1", co2); end
        up_dn = 1'b1;
        load = 1'b1; lv1 = 4'd7; lv2 = 8'h42;
        tick();
        n_cmp++; if (q1 !== 4'd0) begin n_err++; $display("FAIL reset_override: got %h required 0", q1); end
        load = 1'b0;
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] e;
        apply_reset();
        up_dn = 1'b1; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = 4'(i % 10);
            n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL up_q step %0d: got %0d required %0d", i, q1, e); end
            n_cmp++; if (co1 !== (e == 4'd9)) begin n_err++; $display("FAIL up_carry step %0d: got %b required %b", i, co1, (e == 4'd9)); end
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        logic [3:0] e;
        apply_reset();
        up_dn = 1'b0; en = 1'b1;
        #1;
        n_cmp++; if (co1 !== 1'b1) begin n_err++; $display("FAIL down_carry_at0: got %b required 1", co1); end
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = 4'((10 - (i % 10)) % 10);
            n_cmp++; if (q1 !== e) begin n_err++; $display("FAIL down_q step %0d: got %0d required %0d", i, q1, e); end
            n_cmp++; if (co1 !== (e == 4'd0)) begin n_err++; $display("FAIL down_carry step %0d: got %b required %b", i, co1, (e == 4'd0)); end
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        up_dn = 1'b1; en = 1'b1;
        repeat (6) tick();
        n_cmp++; if (q1 !== 4'd6) begin n_err++; $display("FAIL async_pre: got %0d required 6", q1); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (q1 !== 4'd0) begin n_err++; $display("FAIL async_clear_q1: got %0d required 0", q1); end
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL async_clear_q2: got %h required 00", q2); end
        #1;
        rst = 1'b1;
        tick();
        n_cmp++; if (q1 !== 4'd1) begin n_err++; $display("FAIL async_resume: got %0d required 1", q1); end
        en = 1'b0;
    endtask

    task automatic test_hold();
        apply_reset();
        up_dn = 1'b1; en = 1'b1;
        repeat (4) tick();
        n_cmp++; if (q1 !== 4'd4) begin n_err++; $display("FAIL hold_pre: got %0d required 4", q1); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (q1 !== 4'd4) begin n_err++; $display("FAIL hold_q cycle %0d: got %0d required 4", i, q1); end
            n_cmp++; if (co1 !== 1'b0) begin n_err++; $display("FAIL hold_carry cycle %0d: got %b required 0", i, co1); end
        end
    endtask

    task automatic test_load();
        apply_reset();
        up_dn = 1'b1; en = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
        load = 1'b1; lv1 = 4'h7; lv2 = 8'h42;
        tick();
        n_cmp++; if (q1 !== 4'd7) begin n_err++; $display("FAIL load_7: got %h required 7", q1); end
        n_cmp++; if (q2 !== 8'h42) begin n_err++; $display("FAIL load_42: got %h required 42", q2); end
        lv1 = 4'hC; lv2 = 8'hA5;
        tick();
        n_cmp++; if (q1 !== 4'd0) begin n_err++; $display("FAIL load_C: got %h required 0", q1); end
        n_cmp++; if (q2 !== 8'h05) begin n_err++; $display("FAIL load_A5: got %h required 05", q2); end
        lv1 = 4'h3; lv2 = 8'h38; en = 1'b1;
        tick();
        n_cmp++; if (q1 !== 4'd3) begin n_err++; $display("FAIL load_wins: got %h required 3", q1); end
        n_cmp++; if (q2 !== 8'h38) begin n_err++; $display("FAIL load_wins2: got %h required 38", q2); end
        load = 1'b0;
        tick();
        n_cmp++; if (q1 !== 4'd4) begin n_err++; $display("FAIL load_then_count: got %h required 4", q1); end
        n_cmp++; if (q2 !== 8'h39) begin n_err++; $display("FAIL load_then_count2: got %h required 39", q2); end
`else
        load = 1'b1; lv1 = 4'h7; lv2 = 8'h42;
        tick();
        n_cmp++; if (q1 !== 4'd0) begin n_err++; $display("FAIL noload_hold: got %h required 0", q1); end
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL noload_hold2: got %h required 00", q2); end
        en = 1'b1;
        tick();
        n_cmp++; if (q1 !== 4'd1) begin n_err++; $display("FAIL noload_count: got %h required 1", q1); end
        n_cmp++; if (q2 !== 8'h01) begin n_err++; $display("FAIL noload_count2: got %h required 01", q2); end
        load = 1'b0;
`endif
        en = 1'b0;
    endtask

    task automatic test_two_digit();
        logic [7:0] e;
        apply_reset();
        up_dn = 1'b1; en = 1'b1;
        repeat (9) tick();
        n_cmp++; if (q2 !== 8'h09) begin n_err++; $display("FAIL dd_09: got %h required 09", q2); end
        n_cmp++; if (co2 !== 1'b0) begin n_err++; $display("FAIL dd_co_09: got %b required 0", co2); end
        tick();
        n_cmp++; if (q2 !== 8'h10) begin n_err++; $display("FAIL dd_10: got %h required 10", q2); end
        for (int v = 11; v <= 99; v++) begin
            tick();
            e = {4'(v / 10), 4'(v % 10)};
            n_cmp++; if (q2 !== e) begin n_err++; $display("FAIL dd_up_q: got %h required %h", q2, e); end
            n_cmp++; if (co2 !== (v == 99)) begin n_err++; $display("FAIL dd_up_carry at %0d: got %b required %b", v, co2, (v == 99)); end
        end
        tick();
        n_cmp++; if (q2 !== 8'h00) begin n_err++; $display("FAIL dd_wrap_up: got %h required 00", q2); end
        n_cmp++; if (co2 !== 1'b0) begin n_err++; $display("FAIL dd_co_after_wrap: got %b required 0", co2); end
        up_dn = 1'b0;
        #1;
        n_cmp++; if (co2 !== 1'b1) begin n_err++; $display("FAIL dd_co_down_00: got %b required 1", co2); end
        tick();
        n_cmp++; if (q2 !== 8'h99) begin n_err++; $display("FAIL dd_wrap_down: got %h required 99", q2); end
        n_cmp++; if (co2 !== 1'b0) begin n_err++; $display("FAIL dd_co_down_99: got %b required 0", co2); end
        tick();
        n_cmp++; if (q2 !== 8'h98) begin n_err++; $display("FAIL dd_98: got %h required 98", q2); end
        tick();
        tick();
        n_cmp++; if (q2 !== 8'h96) begin n_err++; $display("FAIL dd_96: got %h required 96", q2); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_async_reset();
        test_hold();
        test_load();
        test_two_digit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
